// File: rtl/anycore_l15_req_arbiter.sv
// Buffers one I-fill, one load and one store request and issues them round-robin,
// one at a time, onto the single L1.5 transducer request port.
module anycore_l15_req_arbiter #(
  parameter int PA_W      = 40,
  parameter int IC_ADDR_W = 35,
  parameter int IC_OFF    = 5,
  parameter int DC_ADDR_W = 35,
  parameter int DC_OFF    = 5,
  parameter int ST_ADDR_W = 37
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ic_valid,
  input  logic [IC_ADDR_W-1:0] ic_addr,
  output logic                 ic_ready,
  input  logic                 ld_valid,
  input  logic [DC_ADDR_W-1:0] ld_addr,
  output logic                 ld_ready,
  input  logic                 st_valid,
  input  logic [ST_ADDR_W-1:0] st_addr,
  input  logic [63:0]          st_data,
  input  logic [2:0]           st_size,
  output logic                 st_ready,
  input  logic                 l15_transducer_ack,
  output logic                 arb_l15_val,
  output logic [4:0]           arb_l15_rqtype,
  output logic [2:0]           arb_l15_size,
  output logic [PA_W-1:0]      arb_l15_address,
  output logic [63:0]          arb_l15_data,
  output logic                 arb_l15_nc,
  output logic                 busy,
  output logic                 overflow_err
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  typedef enum logic [1:0] {SEL_IF = 2'd0, SEL_LD = 2'd1, SEL_ST = 2'd2} sel_t;

  localparam logic [4:0] IMISS_RQ   = 5'b10000;
  localparam logic [4:0] LOAD_RQ    = 5'b00000;
  localparam logic [4:0] STORE_RQ   = 5'b00001;
  localparam logic [2:0] PCX_SZ_4B  = 3'b010;
  localparam logic [2:0] PCX_SZ_16B = 3'b111;

  state_t r_state, w_stateNext;
  sel_t   r_last, w_sel;

  logic                 r_ifValid, r_ldValid, r_stValid;
  logic [IC_ADDR_W-1:0] r_ifAddr;
  logic [DC_ADDR_W-1:0] r_ldAddr;
  logic [ST_ADDR_W-1:0] r_stAddr;
  logic [63:0]          r_stData;
  logic [2:0]           r_stSize;

  logic                 r_val, r_ovf;
  logic [4:0]           r_rqtype;
  logic [2:0]           r_size;
  logic [PA_W-1:0]      r_addr;
  logic [63:0]          r_data;

  logic w_anyFull, w_doGrant, w_doAck;
  logic w_clrIf, w_clrLd, w_clrSt;
  logic w_capIf, w_capLd, w_capSt;
  logic w_ovfIf, w_ovfLd, w_ovfSt;
  logic [PA_W-1:0] w_ifPa, w_ldPa, w_stPa, w_nxtAddr;
  logic [4:0]      w_nxtRqtype;
  logic [2:0]      w_nxtSize;
  logic [63:0]     w_nxtData;

  assign w_ifPa = PA_W'({{PA_W{1'b0}}, r_ifAddr} << IC_OFF);
  assign w_ldPa = PA_W'({{PA_W{1'b0}}, r_ldAddr} << DC_OFF);
  assign w_stPa = PA_W'({{PA_W{1'b0}}, r_stAddr} << 3);

  // A slot being cleared by this edge's ack may be refilled on the same edge.
  assign w_clrIf = w_doAck && (r_last == SEL_IF);
  assign w_clrLd = w_doAck && (r_last == SEL_LD);
  assign w_clrSt = w_doAck && (r_last == SEL_ST);
  assign w_capIf = ic_valid && (!r_ifValid || w_clrIf);
  assign w_capLd = ld_valid && (!r_ldValid || w_clrLd);
  assign w_capSt = st_valid && (!r_stValid || w_clrSt);
  assign w_ovfIf = ic_valid && r_ifValid && !w_clrIf;
  assign w_ovfLd = ld_valid && r_ldValid && !w_clrLd;
  assign w_ovfSt = st_valid && r_stValid && !w_clrSt;

  assign w_anyFull = r_ifValid || r_ldValid || r_stValid;

  // Round-robin search starting at the slot after the last grant.
  always_comb begin
    w_sel = r_last;
    case (r_last)
      SEL_IF:  w_sel = r_ldValid ? SEL_LD : (r_stValid ? SEL_ST : SEL_IF);
      SEL_LD:  w_sel = r_stValid ? SEL_ST : (r_ifValid ? SEL_IF : SEL_LD);
      default: w_sel = r_ifValid ? SEL_IF : (r_ldValid ? SEL_LD : SEL_ST);
    endcase
  end

  always_comb begin
    w_nxtRqtype = IMISS_RQ;
    w_nxtSize   = PCX_SZ_4B;
    w_nxtAddr   = w_ifPa;
    w_nxtData   = 64'd0;
    case (w_sel)
      SEL_LD: begin
        w_nxtRqtype = LOAD_RQ;
        w_nxtSize   = PCX_SZ_16B;
        w_nxtAddr   = w_ldPa;
      end
      SEL_ST: begin
        w_nxtRqtype = STORE_RQ;
        w_nxtSize   = r_stSize;
        w_nxtAddr   = w_stPa;
        w_nxtData   = r_stData;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_doGrant   = 1'b0;
    w_doAck     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_anyFull) begin
          w_doGrant   = 1'b1;
          w_stateNext = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (l15_transducer_ack) begin
          w_doAck     = 1'b1;
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifValid <= 1'b0;
      r_ldValid <= 1'b0;
      r_stValid <= 1'b0;
      r_ifAddr  <= '0;
      r_ldAddr  <= '0;
      r_stAddr  <= '0;
      r_stData  <= '0;
      r_stSize  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_capIf) begin
        r_ifValid <= 1'b1;
        r_ifAddr  <= ic_addr;
      end else if (w_clrIf) begin
        r_ifValid <= 1'b0;
      end
      if (w_capLd) begin
        r_ldValid <= 1'b1;
        r_ldAddr  <= ld_addr;
      end else if (w_clrLd) begin
        r_ldValid <= 1'b0;
      end
      if (w_capSt) begin
        r_stValid <= 1'b1;
        r_stAddr  <= st_addr;
        r_stData  <= st_data;
        r_stSize  <= st_size;
      end else if (w_clrSt) begin
        r_stValid <= 1'b0;
      end
      r_ovf <= r_ovf || w_ovfIf || w_ovfLd || w_ovfSt;
    end
  end

  // Request fields are only loaded at grant, so they stay frozen while waiting for ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val    <= 1'b0;
      r_rqtype <= '0;
      r_size   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_last   <= SEL_IF;
    end else if (w_doGrant) begin
      r_val    <= 1'b1;
      r_rqtype <= w_nxtRqtype;
      r_size   <= w_nxtSize;
      r_addr   <= w_nxtAddr;
      r_data   <= w_nxtData;
      r_last   <= w_sel;
    end else if (w_doAck) begin
      r_val    <= 1'b0;
    end
  end

  assign ic_ready        = !r_ifValid;
  assign ld_ready        = !r_ldValid;
  assign st_ready        = !r_stValid;
  assign arb_l15_val     = r_val;
  assign arb_l15_rqtype  = r_rqtype;
  assign arb_l15_size    = r_size;
  assign arb_l15_address = r_addr;
  assign arb_l15_data    = r_data;
  assign arb_l15_nc      = r_addr[PA_W-1];
  assign busy            = (r_state == S_ISSUE);
  assign overflow_err    = r_ovf;

endmodule
